wtc_7seg_dimmer: RTL and testbench

WTC_7SEG_DIMMER -- requirements
Module: wtc_7seg_dimmer

---
 rtl/wtc_7seg_pkg.sv | 23 ++
 rtl/wtc_7seg_fade.sv | 95 +++++++++
 rtl/wtc_7seg_dimmer.sv | 95 +++++++++
 tb/tb_wtc_7seg_dimmer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wtc_7seg_pkg.sv
// Shared constants and types for the 7-segment PWM dimmer.
// Widths, all-off pin patterns and the fade FSM state encoding.
package wtc_7seg_pkg;

  localparam int SEG_W   = 7;
  localparam int LEVEL_W = 4;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

  localparam logic [SEG_W-1:0] SEG_OFF_AL = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_OFF_AH = 7'h00;

  typedef enum logic [1:0] {
    FADE_IDLE = 2'd0,
    FADE_UP   = 2'd1,
    FADE_DOWN = 2'd2
  } fade_state_e;

  function automatic logic [SEG_W-1:0] seg_off(input logic al);
    return al ? SEG_OFF_AL : SEG_OFF_AH;
  endfunction

endpackage

// File: rtl/wtc_7seg_fade.sv
// Brightness fade engine: walks the applied level one step at a time
// toward the target, one step every FADE_PERIODS frames.
module wtc_7seg_fade
  import wtc_7seg_pkg::*;
#(
  parameter int FADE_PERIODS = 16
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_frame,
  input  logic [LEVEL_W-1:0] i_target,
  input  logic               i_en,
  output logic [LEVEL_W-1:0] o_level,
  output logic [LEVEL_W-1:0] o_level_nxt,
  output logic               o_busy
);

  localparam int CW =
    (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam logic [CW-1:0] LAST =
    (FADE_PERIODS > 0) ? CW'(FADE_PERIODS - 1) : '0;

  fade_state_e        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LEVEL_W-1:0] stepped;

  // One level toward the target; never leaves 0..15.
  always_comb begin
    stepped = level_q;
    unique case (1'b1)
      (i_target > level_q): stepped = level_q + 1'b1;
      (i_target < level_q): stepped = level_q - 1'b1;
      default: ;
    endcase
  end

  // Next-state: start, count frames, and step at the boundary.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (i_frame && i_en) begin
      if (FADE_PERIODS == 0) begin
        level_d = i_target;
        state_d = FADE_IDLE;
      end else begin
        unique case (state_q)
          FADE_IDLE: begin
            if (i_target > level_q) begin
              state_d = FADE_UP;
              cnt_d   = '0;
            end else if (i_target < level_q) begin
              state_d = FADE_DOWN;
              cnt_d   = '0;
            end
          end
          FADE_UP, FADE_DOWN: begin
            if (cnt_q == LAST) begin
              level_d = stepped;
              cnt_d   = '0;
              if (stepped == i_target)
                state_d = FADE_IDLE;
              else if (i_target > stepped)
                state_d = FADE_UP;
              else
                state_d = FADE_DOWN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = FADE_IDLE;
        endcase
      end
    end
  end

  // Fade state registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q <= FADE_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level     = level_q;
  assign o_level_nxt = level_d;
  assign o_busy      = (state_q != FADE_IDLE);

endmodule

// File: rtl/wtc_7seg_dimmer.sv
// PWM dimmer for a 7-segment digit: per-frame pattern latch,
// level-dependent on-window, blanking and registered pin drive.
module wtc_7seg_dimmer
  import wtc_7seg_pkg::*;
#(
  parameter int PERIOD_CYCLES = 1200,
  parameter int FADE_PERIODS  = 16,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [SEG_W-1:0]   i_segments,
  input  logic [LEVEL_W-1:0] i_level,
  input  logic               i_blank,
  output logic [SEG_W-1:0]   o_Segment,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_busy,
  output logic               o_frame
);

  localparam int CW = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] STEP = CW'(PERIOD_CYCLES / 15);
  localparam logic [SEG_W-1:0] OFF = seg_off(ACTIVE_LOW);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SEG_W-1:0]   pat_q;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               frame_q;
  logic               frame_start;
  logic [LEVEL_W-1:0] lvl_q, lvl_nxt, lvl_eff;
  logic [SEG_W-1:0]   pat_eff, lit;
  logic [CW-1:0]      thr;
  logic               on;

  assign frame_start = (cnt_q == '0);

  // Frame counter wraps at the end of each PWM frame.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  wtc_7seg_fade #(
    .FADE_PERIODS(FADE_PERIODS)
  ) u_fade (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_frame     (frame_start),
    .i_target    (i_level),
    .i_en        (1'b1),
    .o_level     (lvl_q),
    .o_level_nxt (lvl_nxt),
    .o_busy      (o_busy)
  );

  // In the frame-start cycle the values being latched are
  // already in force, so a new level/pattern covers the whole frame.
  assign lvl_eff = frame_start ? lvl_nxt : lvl_q;
  assign pat_eff = frame_start ? i_segments : pat_q;
  assign thr     = CW'(lvl_eff) * STEP;

  // On-window decode: off, full, or proportional to level.
  always_comb begin
    on = 1'b0;
    unique case (1'b1)
      (lvl_eff == LEVEL_MAX): on = 1'b1;
      (lvl_eff == '0):        on = 1'b0;
      default:                on = (cnt_q < thr);
    endcase
  end

  assign lit   = pat_eff & {SEG_W{on}} & ~{SEG_W{i_blank}};
  assign seg_d = ACTIVE_LOW ? ~lit : lit;

  // Counter, pattern latch and registered pin drive.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      cnt_q   <= '0;
      pat_q   <= '0;
      seg_q   <= OFF;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      if (frame_start)
        pat_q <= i_segments;
      seg_q   <= seg_d;
      frame_q <= frame_start;
    end
  end

  assign o_Segment = seg_q;
  assign o_level   = lvl_q;
  assign o_frame   = frame_q;

endmodule

// File: tb/tb_wtc_7seg_dimmer.sv
// Bench for wtc_7seg_dimmer: two instances (no fade / 2-frame fade)
// driven by shared stimulus and checked against a frame-level model.
module tb_wtc_7seg_dimmer;

  localparam int P = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] lvl;
  logic       blank;

  logic [6:0] s0, s2;
  logic [3:0] l0, l2;
  logic       b0, b2, f0, f2;

  wtc_7seg_dimmer #(
    .PERIOD_CYCLES(P), .FADE_PERIODS(0), .ACTIVE_LOW(1'b1)
  ) u_fp0 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_segments(seg),
    .i_level(lvl), .i_blank(blank), .o_Segment(s0),
    .o_level(l0), .o_busy(b0), .o_frame(f0)
  );

  wtc_7seg_dimmer #(
    .PERIOD_CYCLES(P), .FADE_PERIODS(2), .ACTIVE_LOW(1'b1)
  ) u_fp2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_segments(seg),
    .i_level(lvl), .i_blank(blank), .o_Segment(s2),
    .o_level(l2), .o_busy(b2), .o_frame(f2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int         fp[2] = '{0, 2};
  int         pos;
  bit         m_frame;
  logic [6:0] m_pat[2];
  int         m_lvl[2];
  bit         m_busy[2];
  int         m_age[2];
  logic [6:0] m_seg[2];

  int peak;
  int nframes;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Expected state after one clock edge, from the frame rules.
  task automatic model_step();
    bit fr;
    bit on;
    int tgt;
    if (!rst_n) begin
      pos     = 0;
      m_frame = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_pat[d]  = '0;
        m_lvl[d]  = 0;
        m_busy[d] = 1'b0;
        m_age[d]  = 0;
        m_seg[d]  = 7'h7F;
      end
      return;
    end
    fr  = (pos == 0);
    tgt = int'(lvl);
    for (int d = 0; d < 2; d++) begin
      if (fr) begin
        m_pat[d] = seg;
        if (fp[d] == 0) begin
          m_lvl[d] = tgt;
        end else if (!m_busy[d]) begin
          if (tgt != m_lvl[d]) begin
            m_busy[d] = 1'b1;
            m_age[d]  = 0;
          end
        end else begin
          m_age[d]++;
          if (m_age[d] == fp[d]) begin
            if (tgt > m_lvl[d]) m_lvl[d]++;
            else if (tgt < m_lvl[d]) m_lvl[d]--;
            m_age[d]  = 0;
            m_busy[d] = (m_lvl[d] != tgt);
          end
        end
      end
      on = (m_lvl[d] == 15) ||
           (m_lvl[d] > 0 && pos < m_lvl[d] * (P / 15));
      m_seg[d] = ~(m_pat[d] & ((on && !blank) ? 7'h7F : 7'h00));
    end
    m_frame = fr;
    pos     = (pos + 1) % P;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("seg_fp0",   int'(s0), int'(m_seg[0]));
    chk("seg_fp2",   int'(s2), int'(m_seg[1]));
    chk("frame_fp0", int'(f0), int'(m_frame));
    chk("frame_fp2", int'(f2), int'(m_frame));
    chk("level_fp0", int'(l0), m_lvl[0]);
    chk("level_fp2", int'(l2), m_lvl[1]);
    chk("busy_fp0",  int'(b0), int'(m_busy[0]));
    chk("busy_fp2",  int'(b2), int'(m_busy[1]));
    if (int'(l2) > peak) peak = int'(l2);
    if (f0) nframes++;
  endtask

  typedef struct {
    bit         rst_n;
    logic [6:0] seg;
    logic [3:0] lvl;
    bit         blank;
    int         cycles;
    bit         chk;
    int         e_l0;
    int         e_l2;
    int         e_b2;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    bit r, logic [6:0] s, logic [3:0] l, bit b, int n,
    bit c, int el0, int el2, int eb2, string nm);
    vec_t v;
    v.rst_n = r;  v.seg = s;   v.lvl = l;    v.blank = b;
    v.cycles = n; v.chk = c;   v.e_l0 = el0; v.e_l2 = el2;
    v.e_b2 = eb2; v.name = nm;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    seg   = 7'h7F;
    lvl   = 4'd15;
    blank = 1'b0;
    pos   = 0;
    peak  = 0;
    nframes = 0;
    for (int d = 0; d < 2; d++) begin
      m_pat[d] = '0; m_lvl[d] = 0; m_busy[d] = 1'b0;
      m_age[d] = 0;  m_seg[d] = 7'h7F;
    end
    m_frame = 1'b0;

    tbl.push_back(mk(0, 7'h7F, 15, 0,   5, 1,  0, 0, 0, "reset"));
    tbl.push_back(mk(1, 7'h3F,  0, 0,  30, 1,  0, 0, 0, "idle"));
    tbl.push_back(mk(1, 7'h3F,  3, 0, 150, 1,  3, 2, 1, "up_a"));
    tbl.push_back(mk(1, 7'h3F,  3, 0,  60, 1,  3, 3, 0, "up_b"));
    tbl.push_back(mk(1, 7'h3F, 10, 0, 120, 1, 10, 4, 1, "to10_a"));
    tbl.push_back(mk(1, 7'h3F, 10, 0,  60, 1, 10, 5, 1, "to10_b"));
    tbl.push_back(mk(1, 7'h3F,  2, 0, 150, 1,  2, 2, 0, "reverse"));
    tbl.push_back(mk(1, 7'h3F, 15, 0,  15, 0,  0, 0, 0, "full"));
    tbl.push_back(mk(1, 7'h06, 15, 0,  15, 0,  0, 0, 0, "midseg"));
    tbl.push_back(mk(1, 7'h06, 15, 1,  10, 0,  0, 0, 0, "blank"));
    tbl.push_back(mk(1, 7'h06, 15, 0,  20, 0,  0, 0, 0, "unblank"));
    tbl.push_back(mk(0, 7'h06, 15, 0,   1, 1,  0, 0, 0, "rst_fade"));
    tbl.push_back(mk(1, 7'h7F, 15, 0,  60, 1, 15, 0, 1, "max"));

    @(negedge clk);
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      seg   = tbl[i].seg;
      lvl   = tbl[i].lvl;
      blank = tbl[i].blank;
      if (i == 5) peak = 0;
      if (i == 12) nframes = 0;
      for (int c = 0; c < tbl[i].cycles; c++) tick();
      if (tbl[i].chk) begin
        chk({tbl[i].name, "_l0"}, int'(l0), tbl[i].e_l0);
        chk({tbl[i].name, "_l2"}, int'(l2), tbl[i].e_l2);
        chk({tbl[i].name, "_b2"}, int'(b2), tbl[i].e_b2);
      end
      if (i == 6) chk("reverse_peak", peak, 5);
      if (i == 12) chk("max_frames", nframes, 2);
    end

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) lvl = 4'($urandom_range(15));
      if ($urandom_range(49) == 0) seg = 7'($urandom_range(127));
      if ($urandom_range(59) == 0) blank = ~blank;
      rst_n = ($urandom_range(499) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
